bht_update_gen: RTL and testbench
=================================

# bht_update_gen

Bookkeeping block that closes the loop on the branch history table. It records each BHT prediction the frontend consumes (PC, metadata index, predicted direction) in an in-order queue. When the branch unit resolves branches in program order, it pops the oldest record and produces the registered `bht_update` write (valid, pc, taken, index) that trains the BHT. It sits between frontend, branch unit and the BHT update port.

## Interface
- `VLEN`, 64: virtual PC width.
- `INDEX_BITS`, 7: BHT metadata index width (matches BHT index bits).
- `DEPTH`, 8: pending-branch queue depth; power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Synchronous and active-low; sampled on the rising edge of `clk_i`.
- `flush_i` in 1: drops all pending records.
- `push_valid_i` in 1: the frontend consumed a BHT prediction.
- `push_ready_o` out 1: the queue can accept a record (`count_o != DEPTH`).
- `push_pc_i` in VLEN: PC of the predicted branch.
- `push_index_i` in INDEX_BITS: metadata index returned with the prediction.
- `push_taken_i` in 1: predicted direction.
- `resolve_valid_i` in 1: the oldest branch has resolved.
- `resolve_pc_i` in VLEN: PC of the resolved branch.
- `resolve_taken_i` in 1: actual direction.
- `bht_update_valid_o` out 1: BHT write strobe; a one-cycle pulse.
- `bht_update_pc_o` out VLEN: PC for the update.
- `bht_update_taken_o` out 1: resolved direction.
- `bht_update_index_o` out INDEX_BITS: metadata index to write.
- `mispredict_o` out 1: pulse when the resolved direction differs from the predicted direction.
- `orphan_o` out 1: pulse when a resolve arrives while the queue is empty.
- `pc_mismatch_o` out 1: pulse on a head-PC mismatch (see Configuration).
- `count_o` out $clog2(DEPTH)+1: occupancy.

## Operation
- Storage is a circular buffer of {pc, index, taken} with read pointer, write pointer and count registers.
- **Push:** accepted when `push_valid_i && push_ready_o`. The record is written at the write pointer, which then increments modulo DEPTH.
- **Push while full:** the push is ignored and the queue state is unchanged. The frontend must hold its request.
- **Resolve with count > 0:** pops the head. On the next edge:
  - `bht_update_valid_o` = 1;
  - pc and index come from the head record;
  - taken = `resolve_taken_i`;
  - `mispredict_o` = head.taken XOR `resolve_taken_i`.
- **Resolve with count == 0:** no update is produced and `orphan_o` pulses for one cycle. This holds even if a push is accepted in the same cycle; there is no bypass.
- **Push and resolve in the same cycle:** both take effect and count is unchanged. `push_ready_o` is based on the count at the start of the cycle, so a full queue does not accept a push even while it is popping.
- **Flush:**
  - A resolve in the same cycle is still processed and its update is emitted.
  - A push in the same cycle is dropped.
  - Pointers and count go to 0 on the next edge.
- Pointers wrap from DEPTH-1 to 0. Count stays within 0..DEPTH.

## Timing
- Every output is registered except `push_ready_o`, which is a combinational decode of the count register.
- Update latency: the resolve is sampled at edge N and the update/mispredict/orphan pulses are high for the cycle following edge N.
- Back-to-back resolves give back-to-back update pulses, one per cycle. Throughput is 1 push and 1 resolve per cycle.
- Reset values:
  - all pulses 0;
  - `bht_update_pc_o`/`bht_update_index_o`/`bht_update_taken_o` = 0;
  - `count_o` = 0 and pointers = 0;
  - `push_ready_o` = 1 after reset.
- **Reset mid-operation:** pending records are discarded and any pulse that would have fired on that edge is suppressed. Queue storage contents are not cleared; they are don't-care.

## Configuration
- `BHT_UPD_PC_CHECK_EN` defined:
  - Each resolve with count > 0 compares `resolve_pc_i` against head.pc.
  - On mismatch: no update is emitted, `pc_mismatch_o` pulses, and the whole queue is cleared as if flushed (including a same-cycle push).
  - `mispredict_o` stays 0 for that resolve.
- `BHT_UPD_PC_CHECK_EN` undefined:
  - `resolve_pc_i` is ignored and `pc_mismatch_o` is tied to 0.
  - Every resolve with count > 0 emits an update.

## Test plan
- **Reset, then basic push/resolve.** Reset, push {pc=0x1000, idx=5, taken=1}, then resolve taken=1 two cycles later. Required response:
  - one-cycle `bht_update_valid_o`, pc=0x1000, idx=5, taken=1;
  - `mispredict_o`=0;
  - `count_o` 1→0.
- **Fill, full stall, wrap-around.** Push 8 records with pc=0x100·k and alternating taken. Required response:
  - `push_ready_o`=0 at count 8 and a 9th push is ignored;
  - 8 resolves with taken=0 emit updates in push order;
  - `mispredict_o` on the records with k odd (taken=1);
  - 4 further push/resolve pairs exercise pointer wrap correctly.
- **Simultaneous push and resolve at count 3.** Count stays 3; the update carries the old head. At count 8, the same pair pops but the push is refused and count becomes 7.
- **Orphan resolve.** With the queue empty, resolve together with push pc=0x2000. Required response:
  - `orphan_o` pulses and no update is emitted;
  - `count_o`=1;
  - the next resolve updates pc=0x2000.
- **Flush.** Flush with 5 pending records, a same-cycle resolve and a same-cycle push. Required response: one update for the old head, count=0 afterwards, and the pushed record is absent. Also assert `rst_ni`=0 for one cycle while count=4 with a resolve pending: no pulse fires and count=0.
- **`BHT_UPD_PC_CHECK_EN` build.** Resolve pc=0x3004 against head 0x3000. Required response: `pc_mismatch_o` pulses, no update, count=0. In a build without the macro, the same stimulus emits the update for pc=0x3000.

Source files
------------

// File: rtl/bht_update_gen.sv
// In-order queue of consumed BHT predictions; pops on branch resolve and emits the BHT training write.
// Optional head-PC cross-check is enabled with `define BHT_UPD_PC_CHECK_EN.
module bht_update_gen #(
  parameter int unsigned VLEN       = 64,
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_valid_i,
  output logic                    push_ready_o,
  input  logic [VLEN-1:0]         push_pc_i,
  input  logic [INDEX_BITS-1:0]   push_index_i,
  input  logic                    push_taken_i,
  input  logic                    resolve_valid_i,
  input  logic [VLEN-1:0]         resolve_pc_i,
  input  logic                    resolve_taken_i,
  output logic                    bht_update_valid_o,
  output logic [VLEN-1:0]         bht_update_pc_o,
  output logic                    bht_update_taken_o,
  output logic [INDEX_BITS-1:0]   bht_update_index_o,
  output logic                    mispredict_o,
  output logic                    orphan_o,
  output logic                    pc_mismatch_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [VLEN-1:0]       pc;
    logic [INDEX_BITS-1:0] index;
    logic                  taken;
  } rec_t;

  rec_t mem [DEPTH];

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [VLEN-1:0]       upd_pc_q, upd_pc_d;
  logic                  upd_taken_q, upd_taken_d;
  logic [INDEX_BITS-1:0] upd_index_q, upd_index_d;
  logic                  mispredict_q, mispredict_d;
  logic                  orphan_q, orphan_d;
  logic                  pc_mismatch_q, pc_mismatch_d;

  logic push_fire, has_head, pop, pc_bad, emit, clear, mem_we;
  rec_t head, push_rec;

  assign push_ready_o = (count_q != CNT_W'(DEPTH));
  assign push_fire    = push_valid_i && push_ready_o;
  assign has_head     = (count_q != '0);
  assign pop          = resolve_valid_i && has_head;
  assign head         = mem[rd_ptr_q];

`ifdef BHT_UPD_PC_CHECK_EN
  assign pc_bad = pop && (resolve_pc_i != head.pc);
`else
  logic unused_resolve_pc;
  assign unused_resolve_pc = ^resolve_pc_i;
  assign pc_bad = 1'b0;
`endif

  // A PC mismatch discards the whole queue exactly like a flush.
  assign emit   = pop && !pc_bad;
  assign clear  = flush_i || pc_bad;
  assign mem_we = push_fire && !clear;

  assign push_rec.pc    = push_pc_i;
  assign push_rec.index = push_index_i;
  assign push_rec.taken = push_taken_i;

  // Next-state and registered-output decode.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    upd_valid_d   = 1'b0;
    upd_pc_d      = upd_pc_q;
    upd_taken_d   = upd_taken_q;
    upd_index_d   = upd_index_q;
    mispredict_d  = 1'b0;
    orphan_d      = resolve_valid_i && !has_head;
    pc_mismatch_d = pc_bad;

    if (emit) begin
      upd_valid_d  = 1'b1;
      upd_pc_d     = head.pc;
      upd_index_d  = head.index;
      upd_taken_d  = resolve_taken_i;
      mispredict_d = head.taken ^ resolve_taken_i;
    end

    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_index_q   <= '0;
      mispredict_q  <= 1'b0;
      orphan_q      <= 1'b0;
      pc_mismatch_q <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      upd_index_q   <= upd_index_d;
      mispredict_q  <= mispredict_d;
      orphan_q      <= orphan_d;
      pc_mismatch_q <= pc_mismatch_d;
    end
  end

  // Record storage carries no reset; stale entries are never read.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_ptr_q] <= push_rec;
  end

  assign bht_update_valid_o = upd_valid_q;
  assign bht_update_pc_o    = upd_pc_q;
  assign bht_update_taken_o = upd_taken_q;
  assign bht_update_index_o = upd_index_q;
  assign mispredict_o       = mispredict_q;
  assign orphan_o           = orphan_q;
  assign pc_mismatch_o      = pc_mismatch_q;
  assign count_o            = count_q;

endmodule

// File: tb/tb_bht_update_gen.sv
// Self-checking bench for bht_update_gen: table-driven vectors plus loop sequences, checked via an expectation queue.
module tb_bht_update_gen;

  localparam int unsigned VLEN  = 64;
  localparam int unsigned IB    = 7;
  localparam int unsigned DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            push_valid_i = 1'b0;
  logic            push_ready_o;
  logic [VLEN-1:0] push_pc_i = '0;
  logic [IB-1:0]   push_index_i = '0;
  logic            push_taken_i = 1'b0;
  logic            resolve_valid_i = 1'b0;
  logic [VLEN-1:0] resolve_pc_i = '0;
  logic            resolve_taken_i = 1'b0;
  logic            bht_update_valid_o;
  logic [VLEN-1:0] bht_update_pc_o;
  logic            bht_update_taken_o;
  logic [IB-1:0]   bht_update_index_o;
  logic            mispredict_o;
  logic            orphan_o;
  logic            pc_mismatch_o;
  logic [3:0]      count_o;

  always #5 clk = ~clk;

  bht_update_gen #(.VLEN(VLEN), .INDEX_BITS(IB), .DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .push_valid_i       (push_valid_i),
    .push_ready_o       (push_ready_o),
    .push_pc_i          (push_pc_i),
    .push_index_i       (push_index_i),
    .push_taken_i       (push_taken_i),
    .resolve_valid_i    (resolve_valid_i),
    .resolve_pc_i       (resolve_pc_i),
    .resolve_taken_i    (resolve_taken_i),
    .bht_update_valid_o (bht_update_valid_o),
    .bht_update_pc_o    (bht_update_pc_o),
    .bht_update_taken_o (bht_update_taken_o),
    .bht_update_index_o (bht_update_index_o),
    .mispredict_o       (mispredict_o),
    .orphan_o           (orphan_o),
    .pc_mismatch_o      (pc_mismatch_o),
    .count_o            (count_o)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        pv;
    logic [63:0] ppc;
    logic [6:0]  pidx;
    logic        ptk;
    logic        rv;
    logic [63:0] rpc;
    logic        rtk;
    logic        eu;
    logic [63:0] epc;
    logic [6:0]  eidx;
    logic        etk;
    logic        emis;
    logic        eorph;
    logic        epcm;
    int          ecnt;
  } vec_t;

  typedef struct {
    logic        eu;
    logic [63:0] epc;
    logic [6:0]  eidx;
    logic        etk;
    logic        emis;
    logic        eorph;
    logic        epcm;
    int          ecnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, want);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic flush,
                              input logic pv, input logic [63:0] ppc, input logic [6:0] pidx, input logic ptk,
                              input logic rv, input logic [63:0] rpc, input logic rtk,
                              input logic eu, input logic [63:0] epc, input logic [6:0] eidx, input logic etk,
                              input logic emis, input logic eorph, input logic epcm, input int ecnt);
    vec_t v;
    v.rst = rst; v.flush = flush;
    v.pv = pv; v.ppc = ppc; v.pidx = pidx; v.ptk = ptk;
    v.rv = rv; v.rpc = rpc; v.rtk = rtk;
    v.eu = eu; v.epc = epc; v.eidx = eidx; v.etk = etk;
    v.emis = emis; v.eorph = eorph; v.epcm = epcm; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic vec_t v_push(input logic [63:0] pc, input logic [6:0] idx, input logic tk, input int cnt);
    return mk(0, 0, 1, pc, idx, tk, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
  endfunction

  function automatic vec_t v_res(input logic [63:0] pc, input logic [6:0] idx, input logic tk,
                                 input logic mis, input int cnt);
    return mk(0, 0, 0, 0, 0, 0, 1, pc, tk, 1, pc, idx, tk, mis, 0, 0, cnt);
  endfunction

  // Drive one cycle, queue its expectation, then check the registered response after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    rst_ni          = !v.rst;
    flush_i         = v.flush;
    push_valid_i    = v.pv;
    push_pc_i       = v.ppc;
    push_index_i    = v.pidx;
    push_taken_i    = v.ptk;
    resolve_valid_i = v.rv;
    resolve_pc_i    = v.rpc;
    resolve_taken_i = v.rtk;
    e.eu = v.eu; e.epc = v.epc; e.eidx = v.eidx; e.etk = v.etk;
    e.emis = v.emis; e.eorph = v.eorph; e.epcm = v.epcm; e.ecnt = v.ecnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_ni = 1'b1; flush_i = 1'b0; push_valid_i = 1'b0; resolve_valid_i = 1'b0;
    e = exp_q.pop_front();
    chk("update_valid", 64'(bht_update_valid_o), 64'(e.eu));
    if (e.eu) begin
      chk("update_pc",    bht_update_pc_o,             e.epc);
      chk("update_index", 64'(bht_update_index_o),     64'(e.eidx));
      chk("update_taken", 64'(bht_update_taken_o),     64'(e.etk));
    end
    chk("mispredict",  64'(mispredict_o),  64'(e.emis));
    chk("orphan",      64'(orphan_o),      64'(e.eorph));
    chk("pc_mismatch", 64'(pc_mismatch_o), 64'(e.epcm));
    chk("count",       64'(count_o),       64'(e.ecnt));
    chk("push_ready",  64'(push_ready_o),  64'(e.ecnt != DEPTH));
  endtask

  vec_t tbl[13];
  vec_t idle;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 1, 64'h55, 1, 1, 1, 64'h55, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("reset_pc",    bht_update_pc_o,          64'h0);
    chk("reset_index", 64'(bht_update_index_o),  64'h0);
    chk("reset_taken", 64'(bht_update_taken_o),  64'h0);

    // Basic, orphan and same-cycle push/resolve at count 3.
    tbl[0]  = v_push(64'h1000, 5, 1, 1);
    tbl[1]  = idle; tbl[1].ecnt = 1;
    tbl[2]  = v_res(64'h1000, 5, 1, 0, 0);
    tbl[3]  = idle;
    tbl[4]  = mk(0, 0, 1, 64'h2000, 2, 0, 1, 64'h2000, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[5]  = v_res(64'h2000, 2, 0, 0, 0);
    tbl[6]  = v_push(64'h400, 1, 1, 1);
    tbl[7]  = v_push(64'h404, 2, 0, 2);
    tbl[8]  = v_push(64'h408, 3, 1, 3);
    tbl[9]  = mk(0, 0, 1, 64'h40c, 4, 0, 1, 64'h400, 0, 1, 64'h400, 1, 0, 1, 0, 0, 3);
    tbl[10] = v_res(64'h404, 2, 0, 0, 2);
    tbl[11] = v_res(64'h408, 3, 0, 1, 1);
    tbl[12] = v_res(64'h40c, 4, 1, 1, 0);
    foreach (tbl[i]) apply(tbl[i]);

    // Fill to full; ninth push refused.
    for (int k = 0; k < 8; k++) apply(v_push(64'h100 * k, 7'(k), k[0], k + 1));
    apply(v_push(64'h900, 9, 0, 8));
    // Push+resolve while full: pop happens, push refused.
    apply(mk(0, 0, 1, 64'hA00, 10, 0, 1, 64'h0, 0, 1, 64'h0, 0, 0, 0, 0, 0, 7));
    for (int k = 1; k < 8; k++) apply(v_res(64'h100 * k, 7'(k), 0, k[0], 7 - k));

    // Streaming push/resolve pairs across the pointer wrap.
    apply(v_push(64'h5000, 20, 1, 1));
    for (int j = 1; j <= 4; j++)
      apply(mk(0, 0, 1, 64'h5000 + 64'(j), 7'(20 + j), 1'(j % 2 == 0), 1, 64'h5000 + 64'(j - 1), 1,
               1, 64'h5000 + 64'(j - 1), 7'(19 + j), 1, 1'((j - 1) % 2 != 0), 0, 0, 1));
    apply(v_res(64'h5004, 24, 1, 0, 0));

    // Flush with 5 pending, same-cycle resolve and push.
    for (int k = 0; k < 5; k++) apply(v_push(64'h600 + 64'(4 * k), 7'(k), 0, k + 1));
    apply(mk(0, 1, 1, 64'h7000, 30, 1, 1, 64'h600, 1, 1, 64'h600, 0, 1, 1, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 64'h7000, 1, 0, 0, 0, 0, 0, 1, 0, 0));

    // Reset mid-operation with a resolve pending.
    for (int k = 0; k < 4; k++) apply(v_push(64'h800 + 64'(4 * k), 7'(k), 1, k + 1));
    apply(mk(1, 0, 0, 0, 0, 0, 1, 64'h800, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(idle);
    apply(mk(0, 0, 0, 0, 0, 0, 1, 64'h800, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    // Head-PC mismatch with a same-cycle push.
    apply(v_push(64'h3000, 9, 0, 1));
`ifdef BHT_UPD_PC_CHECK_EN
    apply(mk(0, 0, 1, 64'h3100, 11, 0, 1, 64'h3004, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 64'h3100, 0, 0, 0, 0, 0, 0, 1, 0, 0));
`else
    apply(mk(0, 0, 1, 64'h3100, 11, 0, 1, 64'h3004, 1, 1, 64'h3000, 9, 1, 1, 0, 0, 1));
    apply(v_res(64'h3100, 11, 0, 0, 0));
`endif
    apply(idle);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
